// File: rtl/shifts_pkg.sv
// Shared types and the single-position shift step used by the sequential shifter.
package shifts_pkg;

  // Widest operand the step function handles; shifts_seq needs n < MAX_W.
  localparam int unsigned MAX_W = 32;

  typedef enum logic [2:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // One-position step on the low w bits of word; returns {carry_out, next_word}.
  function automatic logic [MAX_W:0] step(input logic [MAX_W-1:0] word,
                                          input logic [2:0]       op,
                                          input int unsigned      w);
    logic [MAX_W-1:0] top_bit;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] nxt;
    logic             msb;
    logic             lsb;
    logic             cout;
    top_bit = MAX_W'(1) << (w - 1);
    mask    = ~({MAX_W{1'b1}} << w);
    msb     = |(word & top_bit);
    lsb     = word[0];
    nxt     = word;
    cout    = 1'b0;
    case (op)
      LSL: begin
        nxt  = (word << 1) & mask;
        cout = msb;
      end
      LSR: begin
        nxt  = word >> 1;
        cout = lsb;
      end
      ASR: begin
        nxt  = (word >> 1) | ({MAX_W{msb}} & top_bit);
        cout = lsb;
      end
      ROL: begin
        nxt  = ((word << 1) & mask) | {{(MAX_W-1){1'b0}}, msb};
        cout = msb;
      end
      ROR: begin
        nxt  = (word >> 1) | ({MAX_W{lsb}} & top_bit);
        cout = lsb;
      end
      default: begin
        nxt  = word;
        cout = 1'b0;
      end
    endcase
    return {cout, nxt};
  endfunction

endpackage

// File: rtl/shifts_seq.sv
// Multi-cycle shifter: captures an operand on start, shifts one place per clock,
// then reports the word, the last bit shifted out and an invalid-op flag.
module shifts_seq
  import shifts_pkg::*;
#(
  parameter int unsigned n = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] data,
  input  logic [2:0]   shift,
  input  logic [2:0]   direccion,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] resultado,
  output logic         carry,
  output logic         invalido
);

  state_t       state_q, state_d;
  logic [n-1:0] work_q, work_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic         carry_q, carry_d;
  logic         inv_q, inv_d;

  logic [MAX_W:0] step_res;
  logic           accept;
  logic           step_unused;

  assign step_unused = ^step_res[MAX_W-1:n];

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    inv_d    = inv_q;
    step_res = step(MAX_W'(work_q), op_q, n);
    accept   = start && (state_q != SHIFT);

    case (state_q)
      IDLE: ;
      SHIFT: begin
        work_d  = step_res[n-1:0];
        carry_d = step_res[MAX_W];
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new request overrides the DONE->IDLE return, giving back-to-back operation.
    if (accept) begin
      work_d  = data;
      cnt_d   = shift;
      op_d    = direccion;
      carry_d = 1'b0;
      inv_d   = (direccion > 3'd4);
      state_d = ((shift != 3'd0) && (direccion <= 3'd4)) ? SHIFT : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
    end
  end

  assign ready     = (state_q != SHIFT);
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign resultado = work_q;
  assign carry     = carry_q;
  assign invalido  = inv_q;

endmodule

// File: tb/tb_shifts_seq.sv
// Directed bench for shifts_seq (n=6): latency, results, flags, busy-ignore,
// back-to-back acceptance and mid-operation reset.
module tb_shifts_seq;

  localparam int N = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] data;
  logic [2:0]   shift;
  logic [2:0]   direccion;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] resultado;
  logic         carry;
  logic         invalido;

  int errors = 0;
  int checks = 0;

  shifts_seq #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .shift     (shift),
    .direccion (direccion),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .carry     (carry),
    .invalido  (invalido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request, let the next posedge accept it.
  task automatic launch(input logic [N-1:0] d, input logic [2:0] s, input logic [2:0] op);
    data      = d;
    shift     = s;
    direccion = op;
    start     = 1'b1;
    @(posedge clk);
    #1 start  = 1'b0;
  endtask

  // Watch cycles 1.. after acceptance; optionally pulse start in cycle 2.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [N-1:0] exp_res, input logic exp_c,
                           input logic exp_inv, input bit poke);
    int lat;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      if (poke && c == 2) begin
        data      = 6'b010101;
        shift     = 3'd1;
        direccion = 3'd0;
        start     = 1'b1;
      end
      if (poke && c == 3) start = 1'b0;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".resultado"}, 32'(resultado), 32'(exp_res));
    chk({tag, ".carry"}, 32'(carry), 32'(exp_c));
    chk({tag, ".invalido"}, 32'(invalido), 32'(exp_inv));
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    $display("op %s: latency=%0d resultado=%b carry=%b invalido=%b", tag, lat, resultado, carry, invalido);
  endtask

  // One idle cycle after done: pulse gone, results held.
  task automatic idle_hold(input string tag, input logic [N-1:0] exp_res, input logic exp_c);
    @(negedge clk);
    chk({tag, ".done_off"}, 32'(done), 32'd0);
    chk({tag, ".hold_res"}, 32'(resultado), 32'(exp_res));
    chk({tag, ".hold_carry"}, 32'(carry), 32'(exp_c));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    data = '0;
    shift = '0;
    direccion = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.ready", 32'(ready), 32'd1);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.resultado", 32'(resultado), 32'd0);
    chk("reset.carry", 32'(carry), 32'd0);
    chk("reset.invalido", 32'(invalido), 32'd0);

    launch(6'b111000, 3'd4, 3'd1);
    wait_done("lsr4", 5, 6'b000011, 1'b1, 1'b0, 1'b0);
    idle_hold("lsr4", 6'b000011, 1'b1);

    @(negedge clk);
    launch(6'b111000, 3'd4, 3'd0);
    wait_done("lsl4", 5, 6'b000000, 1'b0, 1'b0, 1'b0);
    idle_hold("lsl4", 6'b000000, 1'b0);

    @(negedge clk);
    launch(6'b101000, 3'd2, 3'd2);
    wait_done("asr2", 3, 6'b111010, 1'b0, 1'b0, 1'b0);
    idle_hold("asr2", 6'b111010, 1'b0);

    @(negedge clk);
    launch(6'b111000, 3'd2, 3'd3);
    wait_done("rol2", 3, 6'b100011, 1'b1, 1'b0, 1'b0);
    idle_hold("rol2", 6'b100011, 1'b1);

    @(negedge clk);
    launch(6'b000001, 3'd7, 3'd4);
    wait_done("ror7", 8, 6'b100000, 1'b1, 1'b0, 1'b0);
    idle_hold("ror7", 6'b100000, 1'b1);

    @(negedge clk);
    launch(6'b010101, 3'd0, 3'd1);
    wait_done("shift0", 1, 6'b010101, 1'b0, 1'b0, 1'b0);
    idle_hold("shift0", 6'b010101, 1'b0);

    @(negedge clk);
    launch(6'b010101, 3'd3, 3'd6);
    wait_done("inv6", 1, 6'b010101, 1'b0, 1'b1, 1'b0);
    idle_hold("inv6", 6'b010101, 1'b0);

    // Start pulsed in cycle 2 of a busy operation must be dropped.
    @(negedge clk);
    launch(6'b111000, 3'd4, 3'd1);
    wait_done("busy_ign", 5, 6'b000011, 1'b1, 1'b0, 1'b1);
    idle_hold("busy_ign", 6'b000011, 1'b1);

    // Back-to-back: start held during the done cycle of an ASR by 1.
    @(negedge clk);
    launch(6'b100001, 3'd1, 3'd2);
    wait_done("b2b_a", 2, 6'b110000, 1'b1, 1'b0, 1'b0);
    launch(6'b111000, 3'd2, 3'd3);
    @(negedge clk);
    chk("b2b.ready", 32'(ready), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.carry_clr", 32'(carry), 32'd0);
    wait_done("b2b_b", 2, 6'b100011, 1'b1, 1'b0, 1'b0);
    idle_hold("b2b_b", 6'b100011, 1'b1);

    // Reset in cycle 2 of a 5-step shift: abandoned, no done pulse.
    @(negedge clk);
    launch(6'b110011, 3'd5, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.ready", 32'(ready), 32'd1);
    chk("rst_mid.resultado", 32'(resultado), 32'd0);
    chk("rst_mid.carry", 32'(carry), 32'd0);
    chk("rst_mid.done", 32'(done), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("rst_mid.no_done", 32'(seen), 32'd0);
    end
    $display("op rst_mid: busy=%b ready=%b resultado=%b", busy, ready, resultado);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
